// File: rtl/commit_trace_checker.sv
// ---------------------------------------------------------------------------
// commit_trace_checker
//
// Hardware commit-trace checker. Up to SLOTS retire events per cycle (reg,
// hilo or mem writes) are compacted in slot order, stamped with the current
// cycle count and pushed into a DEPTH-entry FIFO. The FIFO head is compared
// with an externally supplied expected-trace stream, one entry per cycle.
// The first failing compare halts checking and captures the offending event.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clear           synchronous clear of FIFO, flags, counters (highest priority)
//   run             enables the cycle counter and event capture
//   ev_valid/kind/addr/data   per-slot retire events, slot 0 oldest
//   exp_valid/skip/kind/addr/data/cyc   expected-trace entry
//   exp_ready       expected entry consumed this cycle
//   mismatch        sticky compare failure (checker halted)
//   overflow        sticky: an event group was dropped for lack of space
//   err_cyc/err_got stamp and {kind,addr,data} of the failing event
//   checked         entries compared and passed (including skips), saturating
//   pending         FIFO occupancy
//
// Expected-stream handshake: an expected entry is taken in every cycle where
// exp_valid and exp_ready are both high. exp_ready depends combinationally on
// exp_valid, on the FIFO being non-empty and on no mismatch having been seen,
// so the expected source may hold exp_valid high indefinitely. In the cycle a
// compare fails exp_ready is high (the expected entry is used up) but the FIFO
// entry stays in place and exp_ready remains low afterwards until rst/clear.
// ---------------------------------------------------------------------------
module commit_trace_checker #(
  parameter int SLOTS     = 6,
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 32,
  parameter int CHECK_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       run,
  input  logic [SLOTS-1:0]           ev_valid,
  input  logic [2*SLOTS-1:0]         ev_kind,
  input  logic [16*SLOTS-1:0]        ev_addr,
  input  logic [64*SLOTS-1:0]        ev_data,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic                       exp_skip,
  input  logic [1:0]                 exp_kind,
  input  logic [15:0]                exp_addr,
  input  logic [63:0]                exp_data,
  input  logic [CYC_W-1:0]           exp_cyc,
  output logic                       mismatch,
  output logic                       overflow,
  output logic [CYC_W-1:0]           err_cyc,
  output logic [81:0]                err_got,
  output logic [31:0]                checked,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] KIND_REG  = 2'd0;
  localparam logic [1:0] KIND_HILO = 2'd1;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;
  logic [CYC_W-1:0] err_cyc_q, err_cyc_d;
  logic [81:0]      err_got_q, err_got_d;
  logic [31:0]      checked_q, checked_d;

  // FIFO storage: data only, never reset (occupancy lives in count_q).
  logic [1:0]       mem_kind [DEPTH];
  logic [15:0]      mem_addr [DEPTH];
  logic [63:0]      mem_data [DEPTH];
  logic [CYC_W-1:0] mem_cyc  [DEPTH];

  // ---------------------------------------------------------------------
  // Capture: filter, compact and place events
  // ---------------------------------------------------------------------
  logic [SLOTS-1:0] keep;
  logic [CW-1:0]    slot_ofs [SLOTS];
  logic [AW-1:0]    wr_idx   [SLOTS];
  logic [CW-1:0]    n_ev;
  logic [CW-1:0]    free_slots;
  logic             do_push;
  logic             do_drop;

  always_comb begin
    keep       = '0;
    n_ev       = '0;
    free_slots = CW'(DEPTH) - count_q;
    for (int s = 0; s < SLOTS; s++) begin
      // Reserved kind and writes to $zero never reach the trace.
      keep[s] = ev_valid[s]
              && (ev_kind[2*s +: 2] != KIND_RSVD)
              && !((ev_kind[2*s +: 2] == KIND_REG) && (ev_addr[16*s +: 16] == 16'd0));
      // Offset of this slot among the kept events: an exclusive prefix count,
      // so invalid or discarded slots leave no hole in the FIFO.
      slot_ofs[s] = n_ev;
      wr_idx[s]   = wr_ptr_q + slot_ofs[s][AW-1:0];
      if (keep[s]) n_ev = n_ev + CW'(1);
    end
    // Space is judged on the occupancy at the start of the cycle; a pop in
    // the same cycle does not make room for this cycle's group.
    do_push = run && !clear && (n_ev != '0) && (n_ev <= free_slots);
    do_drop = run && !clear && (n_ev > free_slots);
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      if (do_push && keep[s]) begin
        mem_kind[wr_idx[s]] <= ev_kind[2*s +: 2];
        mem_addr[wr_idx[s]] <= ev_addr[16*s +: 16];
        mem_data[wr_idx[s]] <= ev_data[64*s +: 64];
        mem_cyc[wr_idx[s]]  <= cyc_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Compare against the FIFO head
  // ---------------------------------------------------------------------
  logic [1:0]       head_kind;
  logic [15:0]      head_addr;
  logic [63:0]      head_data;
  logic [CYC_W-1:0] head_cyc;
  logic             data_eq;
  logic             cyc_eq;
  logic             is_match;
  logic             do_pop;
  logic             do_fail;

  always_comb begin
    head_kind = mem_kind[rd_ptr_q];
    head_addr = mem_addr[rd_ptr_q];
    head_data = mem_data[rd_ptr_q];
    head_cyc  = mem_cyc[rd_ptr_q];
    // hilo carries a full 64-bit value; reg/mem only the low word.
    if (head_kind == KIND_HILO) data_eq = (head_data == exp_data);
    else                        data_eq = (head_data[31:0] == exp_data[31:0]);
    cyc_eq    = (CHECK_CYC == 0) || (head_cyc == exp_cyc);
    is_match  = exp_skip
             || ((head_kind == exp_kind) && (head_addr == exp_addr) && data_eq && cyc_eq);
    // Gated by clear because nothing is consumed in a clearing cycle.
    exp_ready = exp_valid && (count_q != '0) && !mismatch_q && !clear;
    do_pop    = exp_ready && is_match;
    do_fail   = exp_ready && !is_match;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    cyc_d      = cyc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    err_cyc_d  = err_cyc_q;
    err_got_d  = err_got_q;
    checked_d  = checked_q;

    if (clear) begin
      cyc_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      mismatch_d = 1'b0;
      overflow_d = 1'b0;
      err_cyc_d  = '0;
      err_got_d  = '0;
      checked_d  = '0;
    end else begin
      if (run) cyc_d = cyc_q + CYC_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + n_ev[AW-1:0];
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (checked_q != 32'hFFFF_FFFF) checked_d = checked_q + 32'd1;
      end
      count_d = count_q + (do_push ? n_ev : '0) - {{AW{1'b0}}, do_pop};
      if (do_drop) overflow_d = 1'b1;
      if (do_fail) begin
        mismatch_d = 1'b1;
        err_cyc_d  = head_cyc;
        err_got_d  = {head_kind, head_addr, head_data};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      err_cyc_q  <= '0;
      err_got_q  <= '0;
      checked_q  <= '0;
    end else begin
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      err_cyc_q  <= err_cyc_d;
      err_got_q  <= err_got_d;
      checked_q  <= checked_d;
    end
  end

  assign mismatch = mismatch_q;
  assign overflow = overflow_q;
  assign err_cyc  = err_cyc_q;
  assign err_got  = err_got_q;
  assign checked  = checked_q;
  assign pending  = count_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_checker
//
// Directed bench for commit_trace_checker. Two instances share all inputs:
// dut (CHECK_CYC=0) and dut_c (CHECK_CYC=1). The driver pushes the expected
// outcome {mismatch, checked} of each expected entry it presents into exp_q;
// a monitor pops it whenever dut raises exp_ready and compares after the edge.
// ---------------------------------------------------------------------------
module tb_commit_trace_checker;

  localparam int SLOTS = 6;
  localparam int DEPTH = 16;
  localparam int CYC_W = 32;
  localparam int PW    = $clog2(DEPTH) + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared inputs
  logic                  clear = 1'b0;
  logic                  run   = 1'b0;
  logic [SLOTS-1:0]      ev_valid = '0;
  logic [2*SLOTS-1:0]    ev_kind  = '0;
  logic [16*SLOTS-1:0]   ev_addr  = '0;
  logic [64*SLOTS-1:0]   ev_data  = '0;
  logic                  exp_valid = 1'b0;
  logic                  exp_skip  = 1'b0;
  logic [1:0]            exp_kind  = '0;
  logic [15:0]           exp_addr  = '0;
  logic [63:0]           exp_data  = '0;
  logic [CYC_W-1:0]      exp_cyc   = '0;

  // dut outputs
  logic                  exp_ready, mismatch, overflow;
  logic [CYC_W-1:0]      err_cyc;
  logic [81:0]           err_got;
  logic [31:0]           checked;
  logic [PW-1:0]         pending;

  // dut_c outputs
  logic                  c_exp_ready, c_mismatch, c_overflow;
  logic [CYC_W-1:0]      c_err_cyc;
  logic [81:0]           c_err_got;
  logic [31:0]           c_checked;
  logic [PW-1:0]         c_pending;

  commit_trace_checker #(.SLOTS(SLOTS), .DEPTH(DEPTH), .CYC_W(CYC_W), .CHECK_CYC(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run),
    .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_skip(exp_skip),
    .exp_kind(exp_kind), .exp_addr(exp_addr), .exp_data(exp_data), .exp_cyc(exp_cyc),
    .mismatch(mismatch), .overflow(overflow), .err_cyc(err_cyc), .err_got(err_got),
    .checked(checked), .pending(pending)
  );

  commit_trace_checker #(.SLOTS(SLOTS), .DEPTH(DEPTH), .CYC_W(CYC_W), .CHECK_CYC(1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .run(run),
    .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data),
    .exp_valid(exp_valid), .exp_ready(c_exp_ready), .exp_skip(exp_skip),
    .exp_kind(exp_kind), .exp_addr(exp_addr), .exp_data(exp_data), .exp_cyc(exp_cyc),
    .mismatch(c_mismatch), .overflow(c_overflow), .err_cyc(c_err_cyc), .err_got(c_err_got),
    .checked(c_checked), .pending(c_pending)
  );

  // Scoreboard
  logic [32:0] exp_q[$];   // {mismatch, checked} after each consumed expected entry
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_slot(input int s, input logic [1:0] k, input logic [15:0] a,
                          input logic [63:0] d);
    ev_valid[s]        = 1'b1;
    ev_kind[2*s +: 2]  = k;
    ev_addr[16*s +: 16] = a;
    ev_data[64*s +: 64] = d;
  endtask

  task automatic clr_slots();
    ev_valid = '0;
    ev_kind  = '0;
    ev_addr  = '0;
    ev_data  = '0;
  endtask

  task automatic set_exp(input logic skip, input logic [1:0] k, input logic [15:0] a,
                         input logic [63:0] d, input logic [31:0] c,
                         input logic exp_mm, input logic [31:0] exp_checked);
    exp_valid = 1'b1;
    exp_skip  = skip;
    exp_kind  = k;
    exp_addr  = a;
    exp_data  = d;
    exp_cyc   = c;
    exp_q.push_back({exp_mm, exp_checked});
  endtask

  task automatic do_clear();
    exp_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && exp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: exp_ready=1 with no queued outcome (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          @(posedge clk);
          #1;
          check("sb_outcome", 128'({mismatch, checked}), 128'(e));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Directed stimulus
  initial begin
    // Reset state
    ticks(2);
    exp_valid = 1'b1;
    #1;
    check("rst_exp_ready", 128'(exp_ready), 128'(0));
    check("rst_pending",   128'(pending),   128'(0));
    check("rst_checked",   128'(checked),   128'(0));
    check("rst_mismatch",  128'(mismatch),  128'(0));
    check("rst_overflow",  128'(overflow),  128'(0));
    check("rst_err_got",   128'(err_got),   128'(0));
    check("rst_err_cyc",   128'(err_cyc),   128'(0));
    rst = 1'b0;
    exp_valid = 1'b0;
    tick();

    // 1: single reg event at cyc 5
    run = 1'b1;
    ticks(5);
    set_slot(2, 2'd0, 16'd3, 64'h1234);
    set_exp(1'b0, 2'd0, 16'd3, 64'h1234, 32'd0, 1'b0, 32'd1);
    check("t1_no_bypass", 128'(exp_ready), 128'(0));
    tick();
    clr_slots();
    check("t1_pending1",  128'(pending),   128'(1));
    check("t1_exp_ready", 128'(exp_ready), 128'(1));
    tick();
    exp_valid = 1'b0;
    check("t1_checked",  128'(checked),  128'(1));
    check("t1_pending0", 128'(pending),  128'(0));

    // 2: slots 0,3,5 valid plus discarded $zero (slot1) and kind 3 (slot4)
    set_slot(0, 2'd2, 16'h0010, 64'hAA);
    set_slot(1, 2'd0, 16'd0,    64'hDEAD);
    set_slot(3, 2'd0, 16'd4,    64'd1);
    set_slot(4, 2'd3, 16'd9,    64'hBEEF);
    set_slot(5, 2'd1, 16'd0,    64'h1_0000_0002);
    tick();
    clr_slots();
    check("t2_pending3", 128'(pending), 128'(3));
    set_exp(1'b0, 2'd2, 16'h0010, 64'hAA, 32'd0, 1'b0, 32'd2);
    tick();
    check("t2_pending2", 128'(pending), 128'(2));
    set_exp(1'b0, 2'd0, 16'd4, 64'd1, 32'd0, 1'b0, 32'd3);
    tick();
    check("t2_pending1", 128'(pending), 128'(1));
    set_exp(1'b0, 2'd1, 16'd0, 64'h1_0000_0002, 32'd0, 1'b0, 32'd4);
    tick();
    exp_valid = 1'b0;
    check("t2_pending0", 128'(pending), 128'(0));

    // 3: data mismatch, sticky halt, capture continues, clear recovers
    set_slot(0, 2'd0, 16'd4, 64'd1);
    tick();
    clr_slots();
    set_exp(1'b0, 2'd0, 16'd4, 64'd2, 32'd0, 1'b1, 32'd4);
    tick();
    check("t3_mismatch",  128'(mismatch),  128'(1));
    check("t3_err_got",   128'(err_got),   128'({2'd0, 16'd4, 64'd1}));
    check("t3_exp_ready", 128'(exp_ready), 128'(0));
    check("t3_pending",   128'(pending),   128'(1));
    set_slot(0, 2'd0, 16'd9, 64'd9);
    tick();
    clr_slots();
    check("t3_capture_on", 128'(pending), 128'(2));
    check("t3_still_halt", 128'(exp_ready), 128'(0));
    do_clear();
    check("t3_clr_mismatch", 128'(mismatch), 128'(0));
    check("t3_clr_pending",  128'(pending),  128'(0));
    check("t3_clr_checked",  128'(checked),  128'(0));
    check("t3_clr_err_got",  128'(err_got),  128'(0));
    check("t3_clr_err_cyc",  128'(err_cyc),  128'(0));

    // 4: cycle-stamp compare only in the CHECK_CYC=1 instance
    ticks(7);
    set_slot(0, 2'd0, 16'd5, 64'h55);
    tick();
    clr_slots();
    set_exp(1'b0, 2'd0, 16'd5, 64'h55, 32'd8, 1'b0, 32'd1);
    tick();
    exp_valid = 1'b0;
    check("t4_c_mismatch", 128'(c_mismatch), 128'(1));
    check("t4_c_err_cyc",  128'(c_err_cyc),  128'(7));
    check("t4_c_err_got",  128'(c_err_got),  128'({2'd0, 16'd5, 64'h55}));
    check("t4_c_checked",  128'(c_checked),  128'(0));
    check("t4_c_pending",  128'(c_pending),  128'(1));
    check("t4_nocyc_pass", 128'({mismatch, checked}), 128'({1'b0, 32'd1}));
    do_clear();
    ticks(7);
    set_slot(0, 2'd0, 16'd5, 64'h55);
    tick();
    clr_slots();
    set_exp(1'b1, 2'd2, 16'd0, 64'd0, 32'd8, 1'b0, 32'd1);
    tick();
    exp_valid = 1'b0;
    exp_skip  = 1'b0;
    check("t4_c_skip_mm",  128'(c_mismatch), 128'(0));
    check("t4_c_skip_chk", 128'(c_checked),  128'(1));

    // 5: fill 15 entries in 5 groups, 6th group dropped, then drain
    do_clear();
    for (int g = 0; g < 6; g++) begin
      for (int s = 0; s < 3; s++)
        set_slot(s, 2'd0, 16'(g*3 + s + 1), 64'(g*3 + s + 1));
      tick();
      if (g == 4) begin
        check("t5_pending15", 128'(pending),  128'(15));
        check("t5_no_ovf",    128'(overflow), 128'(0));
      end
    end
    clr_slots();
    check("t5_pending_held", 128'(pending),  128'(15));
    check("t5_overflow",     128'(overflow), 128'(1));
    for (int k = 0; k < 15; k++) begin
      set_exp(1'b0, 2'd0, 16'(k + 1), 64'(k + 1), 32'd0, 1'b0, 32'(k + 1));
      tick();
    end
    exp_valid = 1'b0;
    check("t5_drained",   128'(pending),  128'(0));
    check("t5_ovf_stick", 128'(overflow), 128'(1));

    // 6: asynchronous reset mid-stream
    for (int s = 0; s < 4; s++) set_slot(s, 2'd0, 16'(s + 1), 64'(s + 1));
    tick();
    clr_slots();
    check("t6_pending4", 128'(pending), 128'(4));
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_pending",  128'(pending),  128'(0));
    check("t6_rst_overflow", 128'(overflow), 128'(0));
    check("t6_rst_checked",  128'(checked),  128'(0));
    check("t6_rst_mismatch", 128'(mismatch), 128'(0));
    rst = 1'b0;
    exp_valid = 1'b1;
    exp_kind  = 2'd0;
    exp_addr  = 16'd7;
    exp_data  = 64'd7;
    ticks(3);
    check("t6_no_ready", 128'(exp_ready), 128'(0));
    set_slot(0, 2'd0, 16'd7, 64'd7);
    exp_valid = 1'b0;
    set_exp(1'b0, 2'd0, 16'd7, 64'd7, 32'd0, 1'b0, 32'd1);
    tick();
    clr_slots();
    tick();
    exp_valid = 1'b0;
    check("t6_after_rst", 128'(checked), 128'(1));

    ticks(2);
    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
